// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU: single-cycle logic/arith, iterative MUL and optional UDIV/UREM.
// Optional divider enabled by defining ALU_DIV_EN.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       alu_flags
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL
`ifdef ALU_DIV_EN
        , S_DIV
`endif
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opx;
    logic [WIDTH-1:0] opy;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic [WIDTH-1:0] mul_next;
    logic             is_mul;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] res, input logic c, input logic v);
        return {res[WIDTH-1], res == '0, c, v};
    endfunction

    always_comb begin
        add_full = {1'b0, src_a} + {1'b0, src_b};
        sub_full = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        case (alu_control)
            4'b0000: begin
                sc_res = add_full[WIDTH-1:0];
                sc_c   = add_full[WIDTH];
                sc_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_full[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0001: begin
                sc_res = sub_full[WIDTH-1:0];
                sc_c   = sub_full[WIDTH];
                sc_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_full[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0010: sc_res = src_a & src_b;
            4'b0011: sc_res = src_a | src_b;
            4'b0100: sc_res = src_a ^ src_b;
            default: sc_res = '0;
        endcase
    end

    // MUL: acc accumulates, opx is the shifting multiplicand, opy the shifting multiplier.
    assign is_mul   = (alu_control == 4'b0101);
    assign mul_next = opy[0] ? (acc + opx) : acc;

`ifdef ALU_DIV_EN
    // DIV: acc is the partial remainder, opx shifts dividend bits out and quotient bits in.
    logic             is_div;
    logic             want_rem;
    logic             div_zero;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] div_res;

    assign is_div = (alu_control == 4'b0110) || (alu_control == 4'b0111);

    always_comb begin
        div_shift = {acc, opx[WIDTH-1]};
        div_trial = div_shift - {1'b0, opy};
        div_ok    = ~div_trial[WIDTH];
        rem_next  = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_next  = {opx[WIDTH-2:0], div_ok};
        div_res   = want_rem ? rem_next : quo_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            acc        <= '0;
            opx        <= '0;
            opy        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            alu_result <= '0;
            alu_flags  <= 4'b0000;
`ifdef ALU_DIV_EN
            want_rem   <= 1'b0;
            div_zero   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            acc   <= '0;
                            opx   <= src_a;
                            opy   <= src_b;
                            count <= CW'(WIDTH);
                            busy  <= 1'b1;
                            state <= S_MUL;
`ifdef ALU_DIV_EN
                        end else if (is_div) begin
                            acc      <= '0;
                            opx      <= src_a;
                            opy      <= src_b;
                            want_rem <= alu_control[0];
                            div_zero <= (src_b == '0);
                            count    <= CW'(WIDTH);
                            busy     <= 1'b1;
                            state    <= S_DIV;
`endif
                        end else begin
                            alu_result <= sc_res;
                            alu_flags  <= mk_flags(sc_res, sc_c, sc_v);
                            done       <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= mul_next;
                    opx   <= opx << 1;
                    opy   <= opy >> 1;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        alu_result <= mul_next;
                        alu_flags  <= mk_flags(mul_next, 1'b0, 1'b0);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
`ifdef ALU_DIV_EN
                // A zero divisor naturally yields all-ones quotient and remainder = dividend.
                S_DIV: begin
                    acc   <= rem_next;
                    opx   <= quo_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        alu_result <= div_res;
                        alu_flags  <= mk_flags(div_res, 1'b0, div_zero);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle at WIDTH=32 and WIDTH=8.
module tb_alu_multicycle;

`ifdef ALU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start8;
    logic [3:0]  alu_control;
    logic [31:0] src_a, src_b;
    logic        busy32, done32, busy8, done8;
    logic [31:0] res32;
    logic [7:0]  res8;
    logic [3:0]  flags32, flags8;

    int total = 0;
    int bad   = 0;
    bit cur_sel;
    logic [31:0] prev32, prev8;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .alu_control(alu_control),
        .src_a(src_a), .src_b(src_b), .busy(busy32), .done(done32),
        .alu_result(res32), .alu_flags(flags32)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .alu_control(alu_control),
        .src_a(src_a[7:0]), .src_b(src_b[7:0]), .busy(busy8), .done(done8),
        .alu_result(res8), .alu_flags(flags8)
    );

    logic        s_busy, s_done;
    logic [31:0] s_res;
    logic [3:0]  s_flags;
    always_comb begin
        s_busy  = cur_sel ? busy8 : busy32;
        s_done  = cur_sel ? done8 : done32;
        s_res   = cur_sel ? {24'd0, res8} : res32;
        s_flags = cur_sel ? flags8 : flags32;
    end

    typedef struct {
        bit          sel;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        bit          poke;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit is_multi(input logic [3:0] op);
        return (op == 4'd5) || (DIV_ON && (op == 4'd6 || op == 4'd7));
    endfunction

    // Reference: plain integer arithmetic on masked values, {flags, result}.
    function automatic logic [35:0] ref_model(input logic [3:0] op, input logic [31:0] a_in,
                                              input logic [31:0] b_in, input int w);
        longint unsigned m, a, b, r;
        longint sa, sb, ss, half, full;
        logic c, v, n, z;
        m    = (64'd1 << w) - 1;
        a    = a_in & m;
        b    = b_in & m;
        full = longint'(64'd1 << w);
        half = longint'(64'd1 << (w - 1));
        sa   = (a >= half) ? longint'(a) - full : longint'(a);
        sb   = (b >= half) ? longint'(b) - full : longint'(b);
        r = 0; c = 0; v = 0;
        case (op)
            4'd0: begin r = a + b; c = ((r >> w) & 1) != 0; ss = sa + sb; v = (ss >= half) || (ss < -half); end
            4'd1: begin r = a - b; c = (a >= b); ss = sa - sb; v = (ss >= half) || (ss < -half); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a * b;
            4'd6: if (DIV_ON) begin if (b == 0) begin r = m; v = 1; end else r = a / b; end
            4'd7: if (DIV_ON) begin if (b == 0) begin r = a; v = 1; end else r = a % b; end
            default: r = 0;
        endcase
        r = r & m;
        n = ((r >> (w - 1)) & 1) != 0;
        z = (r == 0);
        return {n, z, c, v, r[31:0]};
    endfunction

    task automatic run(input bit sel, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input string nm, input bit poke);
        int w, lat, k, bc;
        bit got, held;
        logic [31:0] prev;
        w    = sel ? 8 : 32;
        lat  = is_multi(op) ? w + 1 : 1;
        prev = sel ? prev8 : prev32;
        cur_sel = sel;
        @(negedge clk);
        alu_control = op; src_a = a; src_b = b;
        if (sel) start8 = 1'b1; else start32 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start32 = 1'b0;
        alu_control = 4'($urandom); src_a = $urandom; src_b = $urandom;
        k = 1; bc = 0; got = 0; held = 1;
        while (!got && k <= w + 8) begin
            if (s_done) got = 1;
            else begin
                if (s_busy) bc++;
                if (s_res !== prev) held = 0;
                if (poke && k == 5) begin
                    alu_control = 4'd0; src_a = 32'd1; src_b = 32'd2;
                    if (sel) start8 = 1'b1; else start32 = 1'b1;
                end else begin
                    start8 = 1'b0; start32 = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        start8 = 1'b0; start32 = 1'b0;
        check({nm, " done seen"}, 32'(got), 32'd1);
        check({nm, " latency"}, k, lat);
        check({nm, " busy cycles"}, bc, lat - 1);
        check({nm, " busy in done cycle"}, 32'(s_busy), 32'd0);
        check({nm, " result held"}, 32'(held), 32'd1);
        check({nm, " result"}, s_res, er);
        check({nm, " flags"}, 32'(s_flags), 32'(ef));
        if (sel) prev8 = er; else prev32 = er;
        @(negedge clk);
        check({nm, " done single pulse"}, 32'(s_done), 32'd0);
    endtask

    initial begin
        int k;
        bit seen;
        logic [35:0] e;
        logic [3:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
        alu_control = 4'd0; src_a = 32'd0; src_b = 32'd0;
        cur_sel = 1'b0; prev32 = 32'd0; prev8 = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset busy32", 32'(busy32), 32'd0);
        check("reset done32", 32'(done32), 32'd0);
        check("reset result32", res32, 32'd0);
        check("reset flags32", 32'(flags32), 32'd0);
        check("reset busy8", 32'(busy8), 32'd0);
        check("reset result8", 32'(res8), 32'd0);

        vt.push_back('{1'b0, 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, 1'b0});
        vt.push_back('{1'b0, 4'd1, 32'd5, 32'd5, 32'd0, 4'b0110, 1'b0});
        vt.push_back('{1'b0, 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1'b0});
        vt.push_back('{1'b0, 4'd3, 32'h0000_000F, 32'h8000_0000, 32'h8000_000F, 4'b1000, 1'b0});
        vt.push_back('{1'b0, 4'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 4'b0100, 1'b0});
        vt.push_back('{1'b0, 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110, 1'b0});
        vt.push_back('{1'b0, 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1000, 1'b0});
        vt.push_back('{1'b0, 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011, 1'b0});
        vt.push_back('{1'b0, 4'd5, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 4'b1000, 1'b1});
        vt.push_back('{1'b0, 4'hF, 32'd5, 32'd3, 32'd0, 4'b0100, 1'b0});
        vt.push_back('{1'b0, 4'd6, 32'd100, 32'd7, DIV_ON ? 32'd14 : 32'd0, DIV_ON ? 4'b0000 : 4'b0100, 1'b0});
        vt.push_back('{1'b0, 4'd7, 32'd100, 32'd7, DIV_ON ? 32'd2 : 32'd0, DIV_ON ? 4'b0000 : 4'b0100, 1'b0});
        vt.push_back('{1'b0, 4'd6, 32'h1234, 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'd0, DIV_ON ? 4'b1001 : 4'b0100, 1'b0});
        vt.push_back('{1'b0, 4'd7, 32'h1234, 32'd0, DIV_ON ? 32'h1234 : 32'd0, DIV_ON ? 4'b0001 : 4'b0100, 1'b0});
        vt.push_back('{1'b1, 4'd5, 32'd16, 32'd16, 32'h00, 4'b0100, 1'b0});
        vt.push_back('{1'b1, 4'd1, 32'd0, 32'd1, 32'hFF, 4'b1000, 1'b0});

        foreach (vt[i])
            run(vt[i].sel, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].fl, $sformatf("vec%0d", i), vt[i].poke);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 8));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'hF;
            e  = ref_model(op, a, b, (i >= 20) ? 8 : 32);
            run(i >= 20, op, a, b, e[31:0], e[35:32], $sformatf("rand%0d op%0d", i, op), 1'b0);
        end

        // Reset during cycle 10 of a MUL.
        cur_sel = 1'b0;
        @(negedge clk);
        alu_control = 4'd5; src_a = 32'h1357; src_b = 32'h2468; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1; start32 = 1'b1; alu_control = 4'd0;
        @(negedge clk);
        reset = 1'b0; start32 = 1'b0;
        check("abort busy", 32'(busy32), 32'd0);
        check("abort done", 32'(done32), 32'd0);
        check("abort result", res32, 32'd0);
        check("abort flags", 32'(flags32), 32'd0);
        prev32 = 32'd0; prev8 = 32'd0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) seen = 1;
        end
        check("abort no late done", 32'(seen), 32'd0);

        // Back-to-back: ADD started in the MUL done cycle.
        @(negedge clk);
        alu_control = 4'd5; src_a = 32'd3; src_b = 32'd4; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        k = 0;
        while (!done32 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b2b mul done", 32'(done32), 32'd1);
        check("b2b mul result", res32, 32'd12);
        alu_control = 4'd0; src_a = 32'd1; src_b = 32'd2; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        check("b2b add done", 32'(done32), 32'd1);
        check("b2b add result", res32, 32'd3);
        check("b2b add busy", 32'(busy32), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
